rf_write_scheduler: RTL

- Owns the single write port of the 8x8-bit register file and shares it between two write requesters: A (ALU result) and B (memory load data).
- After reset it clears the register file by sweeping zeros into every register before accepting any traffic.
- Tracks outstanding writes per register and flags read addresses whose data is not yet committed, so the control unit can stall on RAW hazards.

---
 rtl/rf_sched_pkg.sv | 18 +
 rtl/wr_hold_buf.sv | 38 +++
 rtl/rf_write_scheduler.sv | 135 +++++++++++++
 3 files changed

// File: rtl/rf_sched_pkg.sv
// Shared types and defaults for the register-file write scheduler.
package rf_sched_pkg;

    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_ADDR_WIDTH = 3;
    localparam int DEF_NUM_REGS   = 8;
    // Wide enough that the two live stamps never alias across a wrap.
    localparam int AGE_WIDTH      = 4;

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam logic REQ_A = 1'b0;
    localparam logic REQ_B = 1'b1;

endpackage

// File: rtl/wr_hold_buf.sv
// One-entry holding buffer for a single write requester, carrying an age stamp.
// push is only raised while empty (valid && ready); pop only while full (grant).
module wr_hold_buf
    import rf_sched_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic                  CLK,
    input  logic                  RESET_N,
    input  logic                  push,
    input  logic                  pop,
    input  logic [ADDR_WIDTH-1:0] push_addr,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic [AGE_WIDTH-1:0]  push_age,
    output logic                  full,
    output logic [ADDR_WIDTH-1:0] addr,
    output logic [DATA_WIDTH-1:0] data,
    output logic [AGE_WIDTH-1:0]  age
);

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            full <= 1'b0;
            addr <= '0;
            data <= '0;
            age  <= '0;
        end else if (push) begin
            full <= 1'b1;
            addr <= push_addr;
            data <= push_data;
            age  <= push_age;
        end else if (pop) begin
            full <= 1'b0;
        end
    end

endmodule

// File: rtl/rf_write_scheduler.sv
// Shares the register-file write port between requesters A and B, zero-sweeps
// the file after reset and tracks per-register outstanding writes for RAW stalls.
module rf_write_scheduler
    import rf_sched_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int NUM_REGS   = DEF_NUM_REGS
) (
    input  logic                  CLK,
    input  logic                  RESET_N,
    input  logic                  A_VALID,
    output logic                  A_READY,
    input  logic [ADDR_WIDTH-1:0] A_ADDR,
    input  logic [DATA_WIDTH-1:0] A_DATA,
    input  logic                  B_VALID,
    output logic                  B_READY,
    input  logic [ADDR_WIDTH-1:0] B_ADDR,
    input  logic [DATA_WIDTH-1:0] B_DATA,
    output logic                  RF_WRITE,
    output logic [ADDR_WIDTH-1:0] RF_INADDRESS,
    output logic [DATA_WIDTH-1:0] RF_IN,
    input  logic [ADDR_WIDTH-1:0] RD1_ADDR,
    input  logic [ADDR_WIDTH-1:0] RD2_ADDR,
    output logic                  RD1_PENDING,
    output logic                  RD2_PENDING,
    output logic [NUM_REGS-1:0]   PENDING_MASK,
    output logic                  INIT_DONE,
    output state_t                DBG_STATE
);

    state_t                state;
    logic [ADDR_WIDTH-1:0] sweep_cnt;
    logic                  rr_ptr;
    logic                  wr_tracked;
    logic [AGE_WIDTH-1:0]  age_seq;
    logic [1:0]            cnt      [NUM_REGS];
    logic [1:0]            cnt_next [NUM_REGS];

    logic                  a_full, b_full;
    logic [ADDR_WIDTH-1:0] a_addr, b_addr;
    logic [DATA_WIDTH-1:0] a_data, b_data;
    logic [AGE_WIDTH-1:0]  a_age, b_age, age_diff;
    logic                  a_accept, b_accept, same_addr, a_older;
    logic                  grant_a, grant_b, rr_move, run;

    assign A_READY   = INIT_DONE && !a_full;
    assign B_READY   = INIT_DONE && !b_full;
    assign a_accept  = A_VALID && A_READY;
    assign b_accept  = B_VALID && B_READY;
    assign DBG_STATE = state;
    assign run       = (state == ST_RUN);

    wr_hold_buf #(.ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH)) u_buf_a (
        .CLK(CLK), .RESET_N(RESET_N), .push(a_accept), .pop(grant_a),
        .push_addr(A_ADDR), .push_data(A_DATA), .push_age(age_seq),
        .full(a_full), .addr(a_addr), .data(a_data), .age(a_age)
    );

    wr_hold_buf #(.ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH)) u_buf_b (
        .CLK(CLK), .RESET_N(RESET_N), .push(b_accept), .pop(grant_b),
        .push_addr(B_ADDR), .push_data(B_DATA), .push_age(age_seq),
        .full(b_full), .addr(b_addr), .data(b_data), .age(b_age)
    );

    // Equal stamps mean same-cycle acceptance, which resolves in favour of A.
    assign same_addr = (a_addr == b_addr);
    assign age_diff  = b_age - a_age;
    assign a_older   = !age_diff[AGE_WIDTH-1];
    assign grant_a   = run && a_full &&
                       (!b_full || (same_addr ? a_older : (rr_ptr == REQ_A)));
    assign grant_b   = run && b_full && !grant_a;
    assign rr_move   = run && a_full && b_full && !same_addr;

    always_comb begin
        PENDING_MASK = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            cnt_next[i] = 2'({1'b0, cnt[i]}
                        + {2'b00, (a_accept && (A_ADDR == ADDR_WIDTH'(i)))}
                        + {2'b00, (b_accept && (B_ADDR == ADDR_WIDTH'(i)))}
                        - {2'b00, (wr_tracked && (RF_INADDRESS == ADDR_WIDTH'(i)))});
            PENDING_MASK[i] = (cnt[i] != 2'd0);
        end
    end

    assign RD1_PENDING = PENDING_MASK[RD1_ADDR];
    assign RD2_PENDING = PENDING_MASK[RD2_ADDR];

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state        <= ST_INIT;
            sweep_cnt    <= '0;
            rr_ptr       <= REQ_A;
            wr_tracked   <= 1'b0;
            age_seq      <= '0;
            RF_WRITE     <= 1'b0;
            RF_INADDRESS <= '0;
            RF_IN        <= '0;
            INIT_DONE    <= 1'b0;
            for (int i = 0; i < NUM_REGS; i++) cnt[i] <= 2'd0;
        end else begin
            for (int i = 0; i < NUM_REGS; i++) cnt[i] <= cnt_next[i];
            if (a_accept || b_accept) age_seq <= age_seq + 1'b1;
            case (state)
                ST_INIT: begin
                    // Sweep writes are not tracked, so they never retire a counter.
                    RF_WRITE     <= 1'b1;
                    RF_INADDRESS <= sweep_cnt;
                    RF_IN        <= '0;
                    wr_tracked   <= 1'b0;
                    sweep_cnt    <= sweep_cnt + 1'b1;
                    if (sweep_cnt == ADDR_WIDTH'(NUM_REGS - 1)) state <= ST_RUN;
                end
                ST_RUN: begin
                    INIT_DONE  <= 1'b1;
                    wr_tracked <= grant_a || grant_b;
                    if (grant_a) begin
                        RF_WRITE     <= 1'b1;
                        RF_INADDRESS <= a_addr;
                        RF_IN        <= a_data;
                    end else if (grant_b) begin
                        RF_WRITE     <= 1'b1;
                        RF_INADDRESS <= b_addr;
                        RF_IN        <= b_data;
                    end else begin
                        RF_WRITE <= 1'b0;
                    end
                    if (rr_move) rr_ptr <= grant_a ? REQ_B : REQ_A;
                end
                default: state <= ST_INIT;
            endcase
        end
    end

endmodule
